// File: rtl/packer_stream_scheduler.sv
// packer_stream_scheduler: frame-level round-robin arbiter feeding one data_packer with a per-source confi table
// optional SCHED_FRAME_CNT_EN adds frame_cnt/frame_src outputs
module packer_stream_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int N_SRC = 4,
    parameter int CONFI_WIDTH = 16,
    parameter logic [CONFI_WIDTH-1:0] CONFI_RESET = 16'h0410
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [$clog2(N_SRC)-1:0]      cfg_addr,
    input  logic [CONFI_WIDTH-1:0]        cfg_wdata,
    input  logic [N_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]              s_axis_tvalid,
    output logic [N_SRC-1:0]              s_axis_tready,
    input  logic [N_SRC-1:0]              s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [CONFI_WIDTH-1:0]        confi,
    output logic [$clog2(N_SRC)-1:0]      grant,
    output logic                          busy
`ifdef SCHED_FRAME_CNT_EN
    ,
    output logic [15:0]                   frame_cnt,
    output logic [$clog2(N_SRC)-1:0]      frame_src
`endif
);
    localparam int AW = $clog2(N_SRC);
    typedef enum logic [1:0] {IDLE, CFG, XFER} state_t;
    state_t state;
    logic [AW-1:0] rr_ptr, pick;
    logic [CONFI_WIDTH-1:0] cfg_tab [2**AW];
    logic xfer, done;
    always_comb begin
        pick = rr_ptr;
        for (int k = N_SRC - 1; k >= 0; k--)
            if (s_axis_tvalid[(int'(rr_ptr) + k) % N_SRC]) pick = AW'((int'(rr_ptr) + k) % N_SRC);
    end
    assign xfer = state == XFER;
    assign m_axis_tdata = s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
    assign m_axis_tvalid = xfer & s_axis_tvalid[grant];
    assign m_axis_tlast = xfer & s_axis_tlast[grant];
    assign s_axis_tready = (xfer && m_axis_tready) ? N_SRC'(1) << grant : '0;
    assign done = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant <= '0;
            busy <= 1'b0;
            confi <= CONFI_RESET;
            for (int i = 0; i < 2**AW; i++) cfg_tab[i] <= CONFI_RESET;
        end else begin
            if (cfg_we) cfg_tab[cfg_addr] <= cfg_wdata;
            case (state)
                IDLE: if (|s_axis_tvalid) begin
                    grant <= pick;
                    busy <= 1'b1;
                    state <= CFG;
                end
                CFG: begin
                    confi <= cfg_tab[grant];
                    state <= XFER;
                end
                default: if (done) begin
                    rr_ptr <= (grant == AW'(N_SRC - 1)) ? '0 : grant + 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
`ifdef SCHED_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            frame_src <= '0;
        end else if (done) begin
            frame_cnt <= frame_cnt + 1'b1;
            frame_src <= grant;
        end
    end
`endif
endmodule

// File: tb/tb_packer_stream_scheduler.sv
// tb_packer_stream_scheduler: directed scenarios plus randomized traffic against a frame-level reference model
module tb_packer_stream_scheduler;
    logic clk = 0, reset = 1, cfg_we = 0, m_tready = 0;
    logic [1:0] cfg_addr = 0;
    logic [15:0] cfg_wdata = 0;
    logic [31:0] s_tdata;
    logic [3:0] s_tvalid, s_tready, s_tlast;
    logic [7:0] m_tdata;
    logic m_tvalid, m_tlast, busy;
    logic [15:0] confi;
    logic [1:0] grant;
`ifdef SCHED_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [1:0] frame_src;
    int fc = 0, fs = 0;
`endif
    int errs = 0, checks = 0;
    logic [3:0] en = 0;
    int len [4] = '{4, 4, 4, 4};
    int pos [4] = '{0, 0, 0, 0};
    logic [7:0] base [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    bit rnd = 0;
    int g, k, t, ph, nph, own, ptr, pick_m;
    logic [15:0] tab_m [4];
    logic [15:0] cval;

    always #5 clk = ~clk;

    packer_stream_scheduler dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .confi(confi), .grant(grant), .busy(busy)
`ifdef SCHED_FRAME_CNT_EN
        , .frame_cnt(frame_cnt), .frame_src(frame_src)
`endif
    );

    assign s_tvalid = en;
    always_comb begin
        s_tdata = '0;
        s_tlast = '0;
        for (int i = 0; i < 4; i++) begin
            s_tdata[i*8 +: 8] = base[i] + 8'(pos[i]);
            s_tlast[i] = pos[i] == len[i] - 1;
        end
    end

    function automatic logic [7:0] beat(input int i);
        return base[i] + 8'(pos[i]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        logic [3:0] acc;
        acc = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (reset) pos[i] = 0;
            else if (acc[i]) begin
                if (pos[i] == len[i] - 1) begin
                    pos[i] = 0;
                    if (rnd) len[i] = $urandom_range(1, 5);
                end else pos[i]++;
            end
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        en = 0;
        cfg_we = 0;
        tick();
        reset = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1;
        cfg_addr = a;
        cfg_wdata = d;
    endtask

    initial begin
        // T1: reset held with every source requesting
        reset = 1; en = 4'hF; m_tready = 1;
        tick(); tick();
        chk("t1_ready", 32'(s_tready), 0);
        chk("t1_mvalid", 32'(m_tvalid), 0);
        chk("t1_confi", 32'(confi), 32'h0410);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_grant", 32'(grant), 0);
        // T2: single 16-beat frame from src1
        do_reset();
        len[1] = 16; en = 4'b0010;
        #1;
        chk("t2_idle", 32'(m_tvalid), 0);
        tick();
        chk("t2_grant", 32'(grant), 1);
        chk("t2_busy", 32'(busy), 1);
        chk("t2_cfg_mvalid", 32'(m_tvalid), 0);
        tick();
        for (int b = 0; b < 16; b++) begin
            chk("t2_data", 32'(m_tdata), 32'(b));
            chk("t2_valid", 32'(m_tvalid), 1);
            chk("t2_last", 32'(m_tlast), 32'(b == 15));
            chk("t2_ready", 32'(s_tready), 32'h2);
            tick();
        end
        en = 0;
        #1;
        chk("t2_done_busy", 32'(busy), 0);
        chk("t2_done_mvalid", 32'(m_tvalid), 0);
        // T3: all sources valid, rotation 0,1,2,3,0 with 2-cycle gaps
        do_reset();
        base = '{8'h00, 8'h40, 8'h80, 8'hC0};
        len = '{4, 4, 4, 4};
        en = 4'hF;
        for (int f = 0; f < 5; f++) begin
            g = f % 4;
            #1;
            chk("t3_gap_idle", 32'({busy, m_tvalid}), 0);
            tick();
            chk("t3_gap_cfg", 32'({busy, m_tvalid}), 32'b10);
            chk("t3_grant", 32'(grant), 32'(g));
            tick();
            for (int b = 0; b < 4; b++) begin
                chk("t3_data", 32'(m_tdata), 32'(base[g] + 8'(b)));
                chk("t3_beat_grant", 32'(grant), 32'(g));
                tick();
            end
        end
        // T4: config table writes, mid-frame and coincident with CFG
        do_reset();
        wr(2, 16'h0820);
        tick();
        cfg_we = 0; base[2] = 8'h20; len[2] = 6; en = 4'b0100;
        tick(); tick();
        for (int b = 0; b < 6; b++) begin
            chk("t4_confi", 32'(confi), 32'h0820);
            chk("t4_data", 32'(m_tdata), 32'(8'h20 + 8'(b)));
            if (b == 2) wr(2, 16'h0104); else cfg_we = 0;
            tick();
        end
        chk("t4_hold", 32'(confi), 32'h0820);
        tick();
        wr(2, 16'h0999);
        tick();
        cfg_we = 0;
        chk("t4_next_frame", 32'(confi), 32'h0104);
        for (int b = 0; b < 8; b++) tick();
        chk("t4_cfg_race", 32'(confi), 32'h0999);
        en = 0;
        // T5: backpressure on a src0 frame
        do_reset();
        base[0] = 8'h50; len[0] = 6; en = 4'b0001; m_tready = 1;
        tick(); tick();
        k = 0; t = 0;
        while (k < 6 && t < 40) begin
            m_tready = (t % 2) == 0;
            #1;
            chk("t5_ready", 32'(s_tready), 32'(m_tready));
            chk("t5_valid", 32'(m_tvalid), 1);
            chk("t5_data", 32'(m_tdata), 32'(8'h50 + 8'(k)));
            chk("t5_last", 32'(m_tlast), 32'(k == 5));
            if (m_tready) k++;
            tick();
            t++;
        end
        chk("t5_all_beats", 32'(k), 6);
        en = 0; m_tready = 1;
`ifdef SCHED_FRAME_CNT_EN
        #1;
        chk("t5_frame_cnt", 32'(frame_cnt), 1);
        chk("t5_frame_src", 32'(frame_src), 0);
`endif
        // T6: reset on beat 5 of a src3 frame
        wr(3, 16'hABCD);
        tick();
        cfg_we = 0; base[3] = 8'h90; len[3] = 10; en = 4'b1000;
        tick(); tick();
        for (int b = 0; b < 5; b++) begin
            chk("t6_data", 32'(m_tdata), 32'(8'h90 + 8'(b)));
            tick();
        end
        chk("t6_beat5", 32'(m_tdata), 32'h95);
        chk("t6_confi_pre", 32'(confi), 32'hABCD);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("t6_mvalid", 32'(m_tvalid), 0);
        chk("t6_ready", 32'(s_tready), 0);
        chk("t6_grant", 32'(grant), 0);
        chk("t6_confi", 32'(confi), 32'h0410);
        chk("t6_busy", 32'(busy), 0);
`ifdef SCHED_FRAME_CNT_EN
        chk("t6_frame_cnt", 32'(frame_cnt), 0);
`endif
        // randomized traffic against the frame-level model
        do_reset();
        rnd = 1;
        for (int i = 0; i < 4; i++) begin
            len[i] = $urandom_range(1, 5);
            base[i] = 8'($urandom);
            tab_m[i] = 16'h0410;
        end
        cval = 16'h0410; ph = 0; own = 0; ptr = 0;
`ifdef SCHED_FRAME_CNT_EN
        fc = 0; fs = 0;
`endif
        repeat (600) begin
            en = 4'($urandom);
            m_tready = ($urandom % 4) != 0;
            cfg_we = ($urandom % 5) == 0;
            cfg_addr = 2'($urandom);
            cfg_wdata = 16'($urandom);
            #1;
            chk("r_busy", 32'(busy), 32'(ph != 0));
            chk("r_confi", 32'(confi), 32'(cval));
`ifdef SCHED_FRAME_CNT_EN
            chk("r_frame_cnt", 32'(frame_cnt), 32'(fc));
            chk("r_frame_src", 32'(frame_src), 32'(fs));
`endif
            if (ph != 0) chk("r_grant", 32'(grant), 32'(own));
            if (ph == 2) begin
                chk("r_mvalid", 32'(m_tvalid), 32'(en[own]));
                chk("r_ready", 32'(s_tready), m_tready ? 32'(1) << own : 0);
                if (en[own]) begin
                    chk("r_data", 32'(m_tdata), 32'(beat(own)));
                    chk("r_last", 32'(m_tlast), 32'(pos[own] == len[own] - 1));
                end
            end else chk("r_quiet", 32'({m_tvalid, s_tready}), 0);
            pick_m = -1;
            for (int j = 3; j >= 0; j--) if (en[(ptr + j) % 4]) pick_m = (ptr + j) % 4;
            nph = ph;
            if (ph == 0 && pick_m >= 0) begin
                own = pick_m;
                nph = 1;
            end else if (ph == 1) begin
                cval = tab_m[own];
                nph = 2;
            end else if (ph == 2 && en[own] && m_tready && pos[own] == len[own] - 1) begin
                ptr = (own + 1) % 4;
                nph = 0;
`ifdef SCHED_FRAME_CNT_EN
                fc = (fc + 1) % 65536;
                fs = own;
`endif
            end
            ph = nph;
            if (cfg_we) tab_m[cfg_addr] = cfg_wdata;
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
